// File: rtl/pep_mmacc_splitc_acc_split.sv
// ---------------------------------------------------------------------------
// pep_mmacc_splitc_acc_split
//
// Write-side split of one half-PSI set of accumulated coefficients into two
// quarter-PSI halves, one per GRAM part. The level-1 permutation swap is
// undone first. Each half then goes into its own small FIFO with an
// independent valid/ready output, so the two GRAM parts can stall separately.
//
// Ports
//   clk, s_rst_n        clock, asynchronous active-low reset
//   in_data             [PSI/2][R][MOD_Q_W] accumulated coefficients
//   in_perm_select      level-1 permutation bits (one bit used, see sw_idx)
//   in_rcmd             request command travelling with the set
//   in_vld / in_rdy     input handshake; in_rdy comes from registered state only
//   outX_data           [PSI/4][R][MOD_Q_W] quarter set for GRAM part X
//   outX_rcmd           copy of the rcmd accepted with that quarter set
//   outX_vld / outX_rdy per-part output handshake
//   err_ovf             sticky flag: in_vld was seen while a FIFO was full
//                       (upstream ignored in_rdy); that set is dropped
// ---------------------------------------------------------------------------
module pep_mmacc_splitc_acc_split #(
    parameter int PSI         = 8,
    parameter int R           = 2,
    parameter int MOD_Q_W     = 8,
    parameter int PERM_W      = 4,
    parameter int REQ_CMD_W   = 8,
    parameter int HPSI_SET_ID = 0,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                                   clk,
    input  logic                                   s_rst_n,
    input  logic [PSI/2-1:0][R-1:0][MOD_Q_W-1:0]   in_data,
    input  logic [PERM_W-1:0]                      in_perm_select,
    input  logic [REQ_CMD_W-1:0]                   in_rcmd,
    input  logic                                   in_vld,
    output logic                                   in_rdy,
    output logic [PSI/4-1:0][R-1:0][MOD_Q_W-1:0]   out0_data,
    output logic [REQ_CMD_W-1:0]                   out0_rcmd,
    output logic                                   out0_vld,
    input  logic                                   out0_rdy,
    output logic [PSI/4-1:0][R-1:0][MOD_Q_W-1:0]   out1_data,
    output logic [REQ_CMD_W-1:0]                   out1_rcmd,
    output logic                                   out1_vld,
    input  logic                                   out1_rdy,
    output logic                                   err_ovf
);

    localparam int QPSI   = PSI / 4;
    // Bit of the level-1 permutation word that swaps this instance's halves.
    localparam int SW_IDX = (PSI / 2 * R * HPSI_SET_ID) / (2 * QPSI * R);
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);

    typedef logic [QPSI-1:0][R-1:0][MOD_Q_W-1:0] quarter_t;

    // ------------------------------------------------------------------
    // Permutation undo and half routing
    // ------------------------------------------------------------------
    logic     sw;
    logic     perm_unused;
    quarter_t half_lo;
    quarter_t half_hi;
    quarter_t half_w   [2];

    assign sw          = in_perm_select[SW_IDX];
    // Only one permutation bit matters for this instance.
    assign perm_unused = ^in_perm_select;
    assign half_lo     = in_data[QPSI-1:0];
    assign half_hi     = in_data[PSI/2-1:QPSI];
    assign half_w[0]   = sw ? half_hi : half_lo;
    assign half_w[1]   = sw ? half_lo : half_hi;

    // ------------------------------------------------------------------
    // Shared accept / overflow logic
    // ------------------------------------------------------------------
    logic [OCC_W-1:0]     occ_w      [2];
    logic                 full_w     [2];
    logic                 out_rdy_w  [2];
    logic                 out_vld_w  [2];
    quarter_t             out_data_w [2];
    logic [REQ_CMD_W-1:0] out_rcmd_w [2];

    // Held low through reset and for the cycle in which reset is released;
    // ready appears from the first clock edge after release.
    logic alive_reg;
    logic err_ovf_reg;
    logic accept;
    logic ovf_hit;

    assign out_rdy_w[0] = out0_rdy;
    assign out_rdy_w[1] = out1_rdy;

    assign in_rdy  = alive_reg & ~full_w[0] & ~full_w[1];
    assign accept  = in_vld & in_rdy;
    // A valid while either FIFO is full can only come from an upstream that
    // did not honour in_rdy; the set is not stored.
    assign ovf_hit = in_vld & (full_w[0] | full_w[1]);

    always_ff @(posedge clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            alive_reg   <= 1'b0;
            err_ovf_reg <= 1'b0;
        end else begin
            alive_reg <= 1'b1;
            if (ovf_hit) begin
                err_ovf_reg <= 1'b1;
            end
        end
    end

    assign err_ovf = err_ovf_reg;

    // ------------------------------------------------------------------
    // Per-half FIFOs. Both are written by the same accept, so entries land
    // in identical order and the k-th pop on each side shares one rcmd.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            quarter_t             data_mem [FIFO_DEPTH];
            logic [REQ_CMD_W-1:0] rcmd_mem [FIFO_DEPTH];
            logic [PTR_W-1:0]     wr_ptr_reg;
            logic [PTR_W-1:0]     rd_ptr_reg;
            logic [PTR_W-1:0]     wr_ptr_next;
            logic [PTR_W-1:0]     rd_ptr_next;
            logic [OCC_W-1:0]     occ_reg;
            logic                 pop;

            assign pop = (occ_reg != '0) & out_rdy_w[gi];

            // Pointers wrap at FIFO_DEPTH, which need not be a power of two.
            assign wr_ptr_next = (wr_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            assign rd_ptr_next = (rd_ptr_reg == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

            always_ff @(posedge clk or negedge s_rst_n) begin
                if (!s_rst_n) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    occ_reg    <= '0;
                    for (int i = 0; i < FIFO_DEPTH; i++) begin
                        data_mem[i] <= '0;
                        rcmd_mem[i] <= '0;
                    end
                end else begin
                    if (accept) begin
                        data_mem[wr_ptr_reg] <= half_w[gi];
                        rcmd_mem[wr_ptr_reg] <= in_rcmd;
                        wr_ptr_reg           <= wr_ptr_next;
                    end
                    if (pop) begin
                        rd_ptr_reg <= rd_ptr_next;
                    end
                    // Simultaneous push and pop leaves the count unchanged.
                    case ({accept, pop})
                        2'b10:   occ_reg <= occ_reg + 1'b1;
                        2'b01:   occ_reg <= occ_reg - 1'b1;
                        default: occ_reg <= occ_reg;
                    endcase
                end
            end

            assign occ_w[gi]      = occ_reg;
            assign full_w[gi]     = (occ_reg == OCC_W'(FIFO_DEPTH));
            assign out_vld_w[gi]  = (occ_reg != '0);
            assign out_data_w[gi] = data_mem[rd_ptr_reg];
            assign out_rcmd_w[gi] = rcmd_mem[rd_ptr_reg];
        end
    endgenerate

    assign out0_data = out_data_w[0];
    assign out0_rcmd = out_rcmd_w[0];
    assign out0_vld  = out_vld_w[0];
    assign out1_data = out_data_w[1];
    assign out1_rcmd = out_rcmd_w[1];
    assign out1_vld  = out_vld_w[1];

endmodule

// File: tb/tb_pep_mmacc_splitc_acc_split.sv
module tb_pep_mmacc_splitc_acc_split;

    logic        clk;
    logic        s_rst_n;
    logic [63:0] in_data;
    logic [3:0]  in_perm_select;
    logic [7:0]  in_rcmd;
    logic        in_vld;
    logic        in_rdy;
    logic [31:0] out0_data;
    logic [7:0]  out0_rcmd;
    logic        out0_vld;
    logic        out0_rdy;
    logic [31:0] out1_data;
    logic [7:0]  out1_rcmd;
    logic        out1_vld;
    logic        out1_rdy;
    logic        err_ovf;

    // Second instance handling set 1: swap bit is in_perm_select[1].
    logic        d1_in_rdy;
    logic [31:0] d1_out0_data;
    logic [7:0]  d1_out0_rcmd;
    logic        d1_out0_vld;
    logic        d1_out0_rdy;
    logic [31:0] d1_out1_data;
    logic [7:0]  d1_out1_rcmd;
    logic        d1_out1_vld;
    logic        d1_out1_rdy;
    logic        d1_err_ovf;

    pep_mmacc_splitc_acc_split #(
        .PSI(8), .R(2), .MOD_Q_W(8), .PERM_W(4), .REQ_CMD_W(8),
        .HPSI_SET_ID(0), .FIFO_DEPTH(2)
    ) dut (
        .clk(clk), .s_rst_n(s_rst_n), .in_data(in_data),
        .in_perm_select(in_perm_select), .in_rcmd(in_rcmd),
        .in_vld(in_vld), .in_rdy(in_rdy),
        .out0_data(out0_data), .out0_rcmd(out0_rcmd), .out0_vld(out0_vld), .out0_rdy(out0_rdy),
        .out1_data(out1_data), .out1_rcmd(out1_rcmd), .out1_vld(out1_vld), .out1_rdy(out1_rdy),
        .err_ovf(err_ovf)
    );

    pep_mmacc_splitc_acc_split #(
        .PSI(8), .R(2), .MOD_Q_W(8), .PERM_W(4), .REQ_CMD_W(8),
        .HPSI_SET_ID(1), .FIFO_DEPTH(2)
    ) dut1 (
        .clk(clk), .s_rst_n(s_rst_n), .in_data(in_data),
        .in_perm_select(in_perm_select), .in_rcmd(in_rcmd),
        .in_vld(in_vld), .in_rdy(d1_in_rdy),
        .out0_data(d1_out0_data), .out0_rcmd(d1_out0_rcmd), .out0_vld(d1_out0_vld), .out0_rdy(d1_out0_rdy),
        .out1_data(d1_out1_data), .out1_rcmd(d1_out1_rcmd), .out1_vld(d1_out1_vld), .out1_rdy(d1_out1_rdy),
        .err_ovf(d1_err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    typedef struct {
        logic [63:0] data;
        logic [3:0]  perm;
        logic [7:0]  rcmd;
        logic [31:0] a0;   // dut (set 0) out0
        logic [31:0] a1;   // dut (set 0) out1
        logic [31:0] b0;   // dut1 (set 1) out0
        logic [31:0] b1;   // dut1 (set 1) out1
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  c;
    } ent_t;

    vec_t vecs[6];
    ent_t q0[$];
    ent_t q1[$];

    logic        p0_vld, p0_rdy, p1_vld, p1_rdy;
    logic [31:0] p0_data, p1_data;
    logic [7:0]  p0_rcmd, p1_rcmd;
    int          set_no = 0;

    // One clock of scoreboarded operation. Called right after an edge (+1),
    // with inputs for the coming edge already driven.
    task automatic cycle();
        ent_t e;
        // Held outputs must not change or drop without a pop.
        if (p0_vld && !p0_rdy) begin
            chk("out0_hold_vld", 64'(out0_vld), 64'd1);
            chk("out0_hold_data", {24'd0, p0_rcmd, p0_data}, {24'd0, out0_rcmd, out0_data});
        end
        if (p1_vld && !p1_rdy) begin
            chk("out1_hold_vld", 64'(out1_vld), 64'd1);
            chk("out1_hold_data", {24'd0, p1_rcmd, p1_data}, {24'd0, out1_rcmd, out1_data});
        end
        if (out0_vld && out0_rdy) begin
            if (q0.size() == 0) begin
                chk("out0_unexpected_pop", {24'd0, out0_rcmd, out0_data}, 64'd0);
                if (out0_data == 32'd0 && out0_rcmd == 8'd0) chk("out0_unexpected_vld", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                chk("out0_data", 64'(out0_data), 64'(e.d));
                chk("out0_rcmd", 64'(out0_rcmd), 64'(e.c));
            end
        end
        if (out1_vld && out1_rdy) begin
            if (q1.size() == 0) begin
                chk("out1_unexpected_pop", {24'd0, out1_rcmd, out1_data}, 64'd0);
                if (out1_data == 32'd0 && out1_rcmd == 8'd0) chk("out1_unexpected_vld", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                chk("out1_data", 64'(out1_data), 64'(e.d));
                chk("out1_rcmd", 64'(out1_rcmd), 64'(e.c));
            end
        end
        if (in_vld && in_rdy) begin
            // Model: bit 0 of the permutation word swaps halves for set 0.
            e.c = in_rcmd;
            e.d = in_perm_select[0] ? in_data[63:32] : in_data[31:0];
            q0.push_back(e);
            e.d = in_perm_select[0] ? in_data[31:0] : in_data[63:32];
            q1.push_back(e);
            $display("set %0d accepted data=%h perm=%b rcmd=%h", set_no, in_data, in_perm_select, in_rcmd);
            set_no++;
        end
        p0_vld = out0_vld; p0_rdy = out0_rdy; p0_data = out0_data; p0_rcmd = out0_rcmd;
        p1_vld = out1_vld; p1_rdy = out1_rdy; p1_data = out1_data; p1_rcmd = out1_rcmd;
        @(posedge clk);
        #1;
    endtask

    // Offer set k (marker data) if the DUT is ready, otherwise idle.
    task automatic offer(input int k);
        if (in_rdy) begin
            in_vld         = 1'b1;
            in_perm_select = 4'b0000;
            in_data        = {32'hB000_0000 | 32'(k), 32'hA000_0000 | 32'(k)};
            in_rcmd        = 8'h40 + 8'(k);
        end else begin
            in_vld = 1'b0;
        end
    endtask

    initial begin
        int acc;
        int pops1;
        int k;
        int sent;
        int cyc;

        vecs[0] = '{64'h8877665544332211, 4'b0000, 8'h10, 32'h44332211, 32'h88776655, 32'h44332211, 32'h88776655};
        vecs[1] = '{64'hA1A2A3A4B1B2B3B4, 4'b0001, 8'h11, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hB1B2B3B4, 32'hA1A2A3A4};
        vecs[2] = '{64'h0123456789ABCDEF, 4'b0010, 8'h12, 32'h89ABCDEF, 32'h01234567, 32'h01234567, 32'h89ABCDEF};
        vecs[3] = '{64'hDEADBEEFCAFEF00D, 4'b0011, 8'h13, 32'hDEADBEEF, 32'hCAFEF00D, 32'hDEADBEEF, 32'hCAFEF00D};
        vecs[4] = '{64'hFFFFFFFF00000000, 4'b1100, 8'h14, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF};
        vecs[5] = '{64'h0000000180000000, 4'b1101, 8'h15, 32'h00000001, 32'h80000000, 32'h80000000, 32'h00000001};

        s_rst_n = 1'b0; in_data = '0; in_perm_select = '0; in_rcmd = '0; in_vld = 1'b0;
        out0_rdy = 1'b1; out1_rdy = 1'b1; d1_out0_rdy = 1'b1; d1_out1_rdy = 1'b1;
        p0_vld = 0; p0_rdy = 0; p1_vld = 0; p1_rdy = 0;
        p0_data = '0; p1_data = '0; p0_rcmd = '0; p1_rcmd = '0;

        // ---------------- reset state ----------------
        #22;
        chk("rst_in_rdy", 64'(in_rdy), 64'd0);
        chk("rst_vld", {62'd0, out0_vld, out1_vld}, 64'd0);
        chk("rst_data", {out1_data, out0_data}, 64'd0);
        chk("rst_rcmd", {48'd0, out1_rcmd, out0_rcmd}, 64'd0);
        chk("rst_err_ovf", 64'(err_ovf), 64'd0);
        @(negedge clk);
        s_rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);

        // ---------------- table vectors, both sides free ----------------
        for (int i = 0; i < 6; i++) begin
            in_data = vecs[i].data; in_perm_select = vecs[i].perm;
            in_rcmd = vecs[i].rcmd; in_vld = 1'b1;
            chk("vec_in_rdy", 64'(in_rdy), 64'd1);
            @(posedge clk);
            #1;
            $display("vec %0d data=%h perm=%b out0=%h out1=%h set1_out0=%h set1_out1=%h",
                     i, vecs[i].data, vecs[i].perm, out0_data, out1_data, d1_out0_data, d1_out1_data);
            chk("vec_out_vld", {62'd0, out0_vld, out1_vld}, 64'd3);
            chk("vec_out0_data", 64'(out0_data), 64'(vecs[i].a0));
            chk("vec_out1_data", 64'(out1_data), 64'(vecs[i].a1));
            chk("vec_rcmd", {48'd0, out1_rcmd, out0_rcmd}, {48'd0, vecs[i].rcmd, vecs[i].rcmd});
            chk("vec_set1_out0_data", 64'(d1_out0_data), 64'(vecs[i].b0));
            chk("vec_set1_out1_data", 64'(d1_out1_data), 64'(vecs[i].b1));
        end

        // ---------------- 16 back-to-back pass-through sets ----------------
        for (int i = 0; i < 16; i++) begin
            in_data = {32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
            in_perm_select = 4'b0000; in_rcmd = 8'h80 + 8'(i); in_vld = 1'b1;
            chk("b2b_in_rdy", 64'(in_rdy), 64'd1);
            @(posedge clk);
            #1;
            $display("b2b %0d out0=%h out1=%h rcmd=%h", i, out0_data, out1_data, out0_rcmd);
            chk("b2b_out0_data", {31'd0, out0_vld, out0_data}, {31'd0, 1'b1, 32'h1000_0000 + 32'(i)});
            chk("b2b_out1_data", {31'd0, out1_vld, out1_data}, {31'd0, 1'b1, 32'h2000_0000 + 32'(i)});
            chk("b2b_rcmd", {48'd0, out1_rcmd, out0_rcmd}, {48'd0, 8'h80 + 8'(i), 8'h80 + 8'(i)});
        end
        in_vld = 1'b0;
        @(posedge clk);
        #1;
        chk("b2b_drained", {62'd0, out0_vld, out1_vld}, 64'd0);

        // ---------------- independent stall of out0 ----------------
        out0_rdy = 1'b0; out1_rdy = 1'b1;
        acc = 0; pops1 = 0; k = 0;
        for (int c = 0; c < 10; c++) begin
            offer(k);
            if (in_vld && in_rdy) begin acc++; k++; end
            if (out1_vld && out1_rdy) pops1++;
            if (out0_vld) chk("stall_out0_head", 64'(out0_data), 64'h0000_0000_A000_0000);
            cycle();
        end
        in_vld = 1'b0;
        chk("stall_accepted", 64'(acc), 64'd2);
        chk("stall_out1_pops", 64'(pops1), 64'd2);
        chk("stall_in_rdy", 64'(in_rdy), 64'd0);
        out0_rdy = 1'b1;
        cycle();
        chk("stall_rdy_return", 64'(in_rdy), 64'd1);
        cycle();
        chk("stall_drained", {62'd0, out0_vld, out1_vld}, 64'd0);
        chk("stall_queues_empty", 64'(q0.size() + q1.size()), 64'd0);

        // ---------------- random ready on both sides ----------------
        sent = 0; cyc = 0;
        while ((sent < 1000 || q0.size() != 0 || q1.size() != 0) && cyc < 20000) begin
            out0_rdy = 1'($urandom_range(1, 0));
            out1_rdy = 1'($urandom_range(1, 0));
            if (sent < 1000 && in_rdy) begin
                in_vld = 1'b1;
                in_data = {$urandom, $urandom};
                in_perm_select = 4'($urandom_range(15, 0));
                in_rcmd = 8'(sent);
                sent++;
            end else begin
                in_vld = 1'b0;
            end
            cycle();
            cyc++;
        end
        in_vld = 1'b0;
        chk("random_within_budget", 64'(cyc < 20000), 64'd1);
        chk("random_all_sent", 64'(sent), 64'd1000);
        chk("random_queues_empty", 64'(q0.size() + q1.size()), 64'd0);
        chk("random_err_ovf", 64'(err_ovf), 64'd0);

        // ---------------- overflow injection ----------------
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        offer(100); cycle();
        offer(101); cycle();
        in_vld = 1'b0;
        chk("ovf_full_in_rdy", 64'(in_rdy), 64'd0);
        chk("ovf_err_before", 64'(err_ovf), 64'd0);
        in_vld = 1'b1; in_data = 64'hDEAD_DEAD_DEAD_DEAD; in_rcmd = 8'hFF; in_perm_select = '0;
        cycle();
        in_vld = 1'b0;
        chk("ovf_err_set", 64'(err_ovf), 64'd1);
        out0_rdy = 1'b1; out1_rdy = 1'b1;
        for (int c = 0; c < 4; c++) cycle();
        chk("ovf_queues_empty", 64'(q0.size() + q1.size()), 64'd0);
        chk("ovf_err_sticky", 64'(err_ovf), 64'd1);

        // ---------------- reset with buffered entries ----------------
        out0_rdy = 1'b0; out1_rdy = 1'b0;
        offer(200); cycle();
        offer(201); cycle();
        in_vld = 1'b0;
        chk("prerst_vld", {62'd0, out0_vld, out1_vld}, 64'd3);
        #2;
        s_rst_n = 1'b0;
        #1;
        chk("midrst_vld", {62'd0, out0_vld, out1_vld}, 64'd0);
        chk("midrst_data", {out1_data, out0_data}, 64'd0);
        chk("midrst_in_rdy", 64'(in_rdy), 64'd0);
        chk("midrst_err_ovf", 64'(err_ovf), 64'd0);
        q0.delete(); q1.delete();
        p0_vld = 1'b0; p1_vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        s_rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rerst_in_rdy", 64'(in_rdy), 64'd1);
        chk("rerst_vld", {62'd0, out0_vld, out1_vld}, 64'd0);
        out0_rdy = 1'b1; out1_rdy = 1'b1;
        for (int c = 0; c < 3; c++) cycle();
        chk("rerst_no_stale", {62'd0, out0_vld, out1_vld}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pep_mmacc_splitc_acc_split.md
# pep_mmacc_splitc_acc_split

Write-side counterpart of the split-GRAM feed join in the pe_pbs monomial-multiply/accumulate path. Receives one half-PSI set of accumulated coefficients (PSI/2 × R words) with its request command. Undoes the level-1 permutation swap, then splits the set into two quarter-PSI halves. Each half goes to its own GRAM part through an independent valid/ready channel with a small per-half output FIFO, so the two GRAM parts can stall independently.

## Interface
- HPSI_SET_ID, 0: which of the two R*PSI/2 coefficient sets this instance handles; selects the permutation bit.
- FIFO_DEPTH, 2: entries per half FIFO; legal values are ≥2.
- clk  in  1  clock
- s_rst_n  in  1  reset, asynchronous, active-low
- in_data  in  [PSI/2][R][MOD_Q_W]  accumulated coefficients
- in_perm_select  in  PERM_W  level-1 permutation bits
- in_rcmd  in  REQ_CMD_W  request command for this set
- in_vld  in  1  input valid
- in_rdy  out  1  input ready
- outX_data (X=0,1)  out  [PSI/4][R][MOD_Q_W]  quarter set going to GRAM part X
- outX_rcmd  out  REQ_CMD_W  copy of in_rcmd
- outX_vld  out  1  valid
- outX_rdy  in  1  ready
- err_ovf  out  1  sticky error flag; see Operation

## Operation
- Swap bit: sw = in_perm_select[(PSI/2*R*HPSI_SET_ID)/(2*(PSI/4)*R)].
- Half routing:
  - Low half = in_data[PSI/4-1:0]; high half = in_data[PSI/2-1:PSI/4].
  - half0 = sw ? high : low.
  - half1 = sw ? low : high.
- Accept: in_vld & in_rdy. On accept, {half0, in_rcmd} is pushed into FIFO0 and {half1, in_rcmd} into FIFO1 in the same cycle.
- in_rdy = (occ0 < FIFO_DEPTH) & (occ1 < FIFO_DEPTH).
  - Depends on registered occupancy only.
  - No combinational path from outX_rdy to in_rdy.
- Each FIFO drains independently.
  - Pop X = outX_vld & outX_rdy.
  - outX_vld = (occX != 0).
  - outX_data and outX_rcmd present the head entry.
- occX update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop (including at occ=1).
  - Range is 0..FIFO_DEPTH.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Ordering: both FIFOs receive entries in identical order. The k-th pop of out0 and the k-th pop of out1 carry the same rcmd.
- err_ovf: set when a push is attempted with occX == FIFO_DEPTH. This is an in_vld that ignores in_rdy and only happens with a protocol-violating upstream. The push is dropped. The flag clears only on reset.
- in_data and in_perm_select are sampled only on accept; values outside accept cycles are ignored.

## Timing
- Reset value of every output:
  - in_rdy=0 while s_rst_n=0, and 1 from the first clock edge after release.
  - outX_vld=0, outX_data=0, outX_rcmd=0, err_ovf=0.
  - FIFO storage, pointers and occupancy all reset to 0.
- Reset asserted mid-operation discards all FIFO contents asynchronously and drops all valids immediately.
- Latency: data accepted at edge t appears on outX with outX_vld=1 after edge t (one cycle).
- Throughput with outX_rdy=1 continuously: one set per cycle, sustained, with occX ≤ 1.
- Back-pressure:
  - out0 stalled, out1 free: FIFO1 drains and FIFO0 fills.
  - in_rdy drops in the cycle after occ0 reaches FIFO_DEPTH.
  - in_rdy returns in the cycle after the first out0 pop.
- Valid/ready rules:
  - Once outX_vld=1, outX_data and outX_rcmd hold stable until popped.
  - outX_vld never deasserts without a pop.
- Maximum skew between the two halves is FIFO_DEPTH entries.

## Test plan
- Pass-through, sw=0, PSI=8, R=2, both outX_rdy=1, 16 back-to-back sets:
  - out0 carries in_data[1:0] and out1 carries in_data[3:2] for every set.
  - Output is one cycle after input.
  - in_rdy stays 1 throughout.
- Swap, sw=1 (HPSI_SET_ID=0, bit 0 set):
  - out0 = in_data[3:2], out1 = in_data[1:0].
  - With HPSI_SET_ID=1 the bit index changes to PSI/2*R/(PSI/2*R)=1; check that bit is the one used.
- Independent stall, out0_rdy=0 for 10 cycles, out1_rdy=1, FIFO_DEPTH=2:
  - Exactly 2 sets accepted, then in_rdy=0.
  - out1 delivers 2 sets; out0 holds set 0 stable.
  - After out0_rdy=1, sets arrive in order with matching rcmd on both sides.
- Random outX_rdy (50%) on each side, 1000 sets:
  - Scoreboard: per-side order preserved and rcmd pairing intact.
  - No loss or duplication; err_ovf=0.
- Overflow injection: force in_vld=1 while in_rdy=0 at full → err_ovf=1 next cycle, the forced set is absent from outputs, and the flag stays set until reset.
- Reset with 2 entries buffered on each side → outX_vld=0 immediately; after release in_rdy=1, occX=0, and no stale data is emitted.
